int_bus_arbiter: RTL and testbench
==================================

Name: int_bus_arbiter

Overview:
- Shares the 16-bit-address / 8-bit-data internal register-file bus between NUM_MASTERS requesters.
- Typical requesters: the UART command parser (via its int_req/int_gnt pair), plus a second master such as a debug or DMA engine.
- Sits between the masters and the register file.
- Provides round-robin grant, command muxing, strobe gating, and a hold-timeout watchdog that forcibly reclaims a stuck grant.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- AW, 16, address width.
- DW, 8, data width.
- MAX_HOLD, 1024, max consecutive cycles one master may hold the grant while another requests; 0 disables the watchdog.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- m_req  in  NUM_MASTERS  per-master bus request.
- m_gnt  out  NUM_MASTERS  per-master grant, one-hot or zero.
- m_address  in  NUM_MASTERS*AW  packed addresses; master i at [i*AW +: AW].
- m_wr_data  in  NUM_MASTERS*DW  packed write data.
- m_write  in  NUM_MASTERS  write strobes.
- m_read  in  NUM_MASTERS  read strobes.
- m_rd_data  out  DW  read data, broadcast to all masters.
- int_address  out  AW  register-file address.
- int_wr_data  out  DW  register-file write data.
- int_write  out  1  register-file write strobe.
- int_read  out  1  register-file read strobe.
- int_rd_data  in  DW  register-file read data.
- owner  out  3  index of the current grant holder; valid while busy.
- busy  out  1  a grant is active.
- hold_timeout  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (reset low, asynchronous):
  - m_gnt = 0, busy = 0, owner = 0, hold_timeout = 0.
  - Round-robin pointer = 0, hold counter = 0, state = IDLE.
- States:
  - IDLE: no grant.
  - GRANT: one master owns the bus.
  - RELEASE: one dead cycle, m_gnt = 0.
- IDLE:
  - If any m_req is high, select the first requester at or after pointer (wrapping modulo NUM_MASTERS).
  - Register m_gnt one-hot and owner; go to GRANT.
  - Grant latency: m_req sampled high in cycle n gives m_gnt high in cycle n+1.
- GRANT:
  - If m_req[owner] is low, go to RELEASE and set pointer = owner+1 (wrapped).
  - Else, if the watchdog fires, go to RELEASE, pulse hold_timeout, and set pointer = owner+1.
- RELEASE:
  - Go to IDLE.
  - Minimum gap between grants to different masters (or a re-grant to the same master) is 2 cycles with m_gnt = 0.
- Request timing: requests raised or dropped during RELEASE are sampled in IDLE. A master that still requests is eligible again, behind the pointer.
- Bus outputs (combinational from registered owner and busy):
  - int_address = m_address[owner]; int_wr_data = m_wr_data[owner].
  - int_write = busy & m_write[owner]; int_read = busy & m_read[owner].
  - Strobes from non-granted masters are ignored entirely.
  - When not busy, int_address and int_wr_data are 0.
- Read data:
  - m_rd_data = int_rd_data (pass-through).
  - The register file returns data with its own latency; only the owner may consume it.
  - The arbiter does not release the grant before the owner drops m_req, so an in-flight read completes.
- Watchdog:
  - Hold counter clears on entering GRANT.
  - It increments each GRANT cycle in which some other m_req bit is high, and saturates at MAX_HOLD.
  - It fires when counter == MAX_HOLD-1 and another request is still pending.
  - It never fires when MAX_HOLD = 0, or when no other master is requesting (a lone master may hold indefinitely).
- Forced release: the owner's strobes are gated off from the RELEASE cycle onward, and the owner sees m_gnt fall. Masters must treat a grant drop as transaction abort.
- Simultaneous events:
  - Owner drops m_req in the same cycle the watchdog would fire: normal release, no hold_timeout pulse.
  - All requesters asserted together: the pointer decides.
- Reset mid-transaction: grant and strobes drop immediately (asynchronous); after reset the pointer restarts at 0.
- m_gnt bits with index >= NUM_MASTERS are never set.

Decomposition:
- Shared package (uart2bus_pkg), holding:
  - Arbiter state encoding constants: ARB_IDLE = 2'd0, ARB_GRANT = 2'd1, ARB_RELEASE = 2'd2.
  - Default bus widths AW = 16, DW = 8.
- One natural sub-module, rr_pick:
  - Combinational round-robin selector.
  - Inputs: req vector, pointer. Outputs: one-hot select, index, any.
  - Reusable by other arbiters in the design.
- The top holds the FSM, hold counter and muxes.

Test Plan:
- Single master (NUM_MASTERS=2):
  - Stimulus: m_req = 2'b01 at cycle 5; write to 0x1234, data 0xA5 at cycle 7; m_req drops at cycle 8.
  - Response: m_gnt = 2'b01 at cycle 6; int_write high at cycle 7 with address 0x1234 and data 0xA5; m_gnt = 0 at cycle 9; busy low at cycle 10.
- Round robin:
  - Stimulus: both m_req held high; each owner drops m_req 3 cycles after its grant, then re-raises it.
  - Response: grants alternate 01, 10, 01, 10, with exactly 2 zero-grant cycles between grants.
- Strobe gating:
  - Stimulus: master 1 pulses m_write with address 0xFFFF while master 0 owns the bus.
  - Response: int_write is 0 and int_address stays at master 0's address.
- Watchdog (MAX_HOLD=8):
  - Stimulus: master 0 holds m_req forever; master 1 requests from cycle 2 after the grant.
  - Response: hold_timeout pulses exactly once; m_gnt[0] falls; master 1 is granted 3 cycles later.
  - Repeat with master 1 idle: no timeout ever.
- Reset mid-operation:
  - Stimulus: assert reset low in the middle of master 1's read.
  - Response: m_gnt, int_read and busy drop at once; after release, with both requesting, master 0 is granted first.
- Read path:
  - Stimulus: register file returns 0x3C one cycle after int_read.
  - Response: m_rd_data = 0x3C in that cycle; the grant is held until the owner drops m_req.

Source files
------------

// File: rtl/uart2bus_pkg.sv
// uart2bus_pkg: shared bus widths and arbiter state encoding for the uart2bus block set.
package uart2bus_pkg;
  localparam int BUS_AW = 16;
  localparam int BUS_DW = 8;
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;
endpackage

// File: rtl/int_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first requester at or after the pointer.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  sel_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    // walk offsets from farthest to nearest so the nearest hit wins
    for (int k = N - 1; k >= 0; k--)
      for (int i = 0; i < N; i++)
        if (i == (int'(ptr_i) + k) % N && req_i[i]) idx_o = IW'(i);
    sel_o = any_o ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/int_bus_arbiter.sv
// int_bus_arbiter: round-robin arbiter for the internal register-file bus with a hold-timeout
// watchdog that reclaims a grant held too long while others wait.
module int_bus_arbiter
  import uart2bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = BUS_AW,
  parameter int DW          = BUS_DW,
  parameter int MAX_HOLD    = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_MASTERS-1:0]    m_req_i,
  output logic [NUM_MASTERS-1:0]    m_gnt_o,
  input  logic [NUM_MASTERS*AW-1:0] m_address_i,
  input  logic [NUM_MASTERS*DW-1:0] m_wr_data_i,
  input  logic [NUM_MASTERS-1:0]    m_write_i,
  input  logic [NUM_MASTERS-1:0]    m_read_i,
  output logic [DW-1:0]             m_rd_data_o,
  output logic [AW-1:0]             int_address_o,
  output logic [DW-1:0]             int_wr_data_o,
  output logic                      int_write_o,
  output logic                      int_read_o,
  input  logic [DW-1:0]             int_rd_data_i,
  output logic [2:0]                owner_o,
  output logic                      busy_o,
  output logic                      hold_timeout_o
);
  localparam int CW = $clog2(MAX_HOLD + 2);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d, pick_sel;
  logic [2:0]             owner_q, owner_d, ptr_q, ptr_d, pick_idx, nxt;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   to_q, to_d, pick_any, own_req, others, fire, busy;

  rr_pick #(.N(NUM_MASTERS), .IW(3)) u_pick (
    .req_i(m_req_i),
    .ptr_i(ptr_q),
    .sel_o(pick_sel),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );

  assign busy    = state_q == ARB_GRANT;
  assign own_req = |(m_req_i & gnt_q);
  assign others  = |(m_req_i & ~gnt_q);
  // an owner dropping its request takes priority over a timeout in the same cycle
  assign fire    = MAX_HOLD != 0 && others && cnt_q == HOLD_LAST;
  assign nxt     = owner_q == 3'(NUM_MASTERS - 1) ? 3'd0 : owner_q + 3'd1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    case (state_q)
      ARB_IDLE: if (pick_any) begin
        state_d = ARB_GRANT;
        gnt_d   = pick_sel;
        owner_d = pick_idx;
        cnt_d   = '0;
      end
      ARB_GRANT: if (!own_req || fire) begin
        state_d = ARB_RELEASE;
        gnt_d   = '0;
        ptr_d   = nxt;
        to_d    = own_req;
      end else if (others && cnt_q != HOLD_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    int_address_o = '0;
    int_wr_data_o = '0;
    int_write_o   = 1'b0;
    int_read_o    = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (busy && owner_q == 3'(i)) begin
        int_address_o = m_address_i[i*AW +: AW];
        int_wr_data_o = m_wr_data_i[i*DW +: DW];
        int_write_o   = m_write_i[i];
        int_read_o    = m_read_i[i];
      end
  end

  assign m_gnt_o        = gnt_q;
  assign m_rd_data_o    = int_rd_data_i;
  assign owner_o        = owner_q;
  assign busy_o         = busy;
  assign hold_timeout_o = to_q;
endmodule

// File: tb/tb_int_bus_arbiter.sv
// tb_int_bus_arbiter: directed tests of grant timing, round robin, strobe gating, watchdog,
// asynchronous reset and read pass-through for a 2-master arbiter with an 8-cycle hold limit.
module tb_int_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_req, m_gnt, m_write, m_read;
  logic [31:0] m_address;
  logic [15:0] m_wr_data;
  logic [7:0]  m_rd_data, int_wr_data, int_rd_data;
  logic [15:0] int_address;
  logic        int_write, int_read, busy, hold_timeout;
  logic [2:0]  owner;
  int          checks = 0;
  int          failures = 0;

  int_bus_arbiter #(.NUM_MASTERS(2), .AW(16), .DW(8), .MAX_HOLD(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .m_req_i(m_req), .m_gnt_o(m_gnt),
    .m_address_i(m_address), .m_wr_data_i(m_wr_data), .m_write_i(m_write), .m_read_i(m_read),
    .m_rd_data_o(m_rd_data), .int_address_o(int_address), .int_wr_data_o(int_wr_data),
    .int_write_o(int_write), .int_read_o(int_read), .int_rd_data_i(int_rd_data),
    .owner_o(owner), .busy_o(busy), .hold_timeout_o(hold_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    m_req = '0; m_write = '0; m_read = '0;
    m_address = '0; m_wr_data = '0; int_rd_data = '0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_gnt(output int gap);
    gap = 0;
    while (m_gnt == 2'b00 && gap < 16) begin
      gap++;
      step();
    end
  endtask

  int gap, pulses, pulse_t, first10;
  logic [1:0] gnt_at_pulse, gnt_before;
  logic wr_at_pulse, wr_before;
  logic [1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_dut();
    check("rst_gnt", m_gnt, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_owner", owner, 3'd0);
    check("rst_to", hold_timeout, 1'b0);
    check("idle_addr", int_address, 16'h0);

    // single master: cycle 0 is now
    repeat (5) step();
    m_req = 2'b01;
    m_address[15:0] = 16'h1234;
    m_wr_data[7:0] = 8'hA5;
    step();
    check("sm_gnt6", m_gnt, 2'b01);
    check("sm_busy6", busy, 1'b1);
    step();
    m_write = 2'b01;
    #1;
    check("sm_wr7", int_write, 1'b1);
    check("sm_addr7", int_address, 16'h1234);
    check("sm_data7", int_wr_data, 8'hA5);
    step();
    m_write = 2'b00;
    m_req = 2'b00;
    check("sm_gnt8", m_gnt, 2'b01);
    step();
    check("sm_gnt9", m_gnt, 2'b00);
    step();
    check("sm_busy10", busy, 1'b0);
    check("sm_addr10", int_address, 16'h0);

    // round robin from a fresh pointer
    reset_dut();
    m_req = 2'b11;
    wait_gnt(gap);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_gnt%0d", k), m_gnt, rr_exp[k]);
      if (k > 0) check($sformatf("rr_gap%0d", k), gap, 2);
      repeat (3) step();
      m_req = m_req & ~m_gnt;
      step();
      m_req = 2'b11;
      wait_gnt(gap);
    end
    m_req = 2'b00;

    // strobe gating
    reset_dut();
    m_address = {16'hFFFF, 16'h0040};
    m_req = 2'b01;
    wait_gnt(gap);
    check("sg_gnt", m_gnt, 2'b01);
    m_write = 2'b10;
    #1;
    check("sg_wr", int_write, 1'b0);
    check("sg_addr", int_address, 16'h0040);
    step();
    m_write = 2'b00;
    m_req = 2'b00;

    // watchdog: master 0 holds, master 1 requests from grant+2
    reset_dut();
    m_req = 2'b01;
    m_write = 2'b01;
    step();
    check("wd_gnt0", m_gnt, 2'b01);
    pulses = 0; pulse_t = -1; first10 = -1;
    gnt_at_pulse = 2'b11; wr_at_pulse = 1'b1; gnt_before = 2'b00; wr_before = 1'b0;
    for (int t = 0; t < 14; t++) begin
      if (t == 2) m_req = 2'b11;
      #1;
      if (t == 9) begin gnt_before = m_gnt; wr_before = int_write; end
      if (hold_timeout) begin
        pulses++; pulse_t = t; gnt_at_pulse = m_gnt; wr_at_pulse = int_write;
      end
      if (m_gnt == 2'b10 && first10 < 0) first10 = t;
      step();
    end
    check("wd_pulses", pulses, 1);
    check("wd_pulse_t", pulse_t, 10);
    check("wd_gnt_before", gnt_before, 2'b01);
    check("wd_wr_before", wr_before, 1'b1);
    check("wd_gnt_fall", gnt_at_pulse, 2'b00);
    check("wd_wr_gated", wr_at_pulse, 1'b0);
    check("wd_m1_gnt_t", first10, 12);

    // lone master never times out
    reset_dut();
    m_req = 2'b01;
    pulses = 0;
    for (int t = 0; t < 40; t++) begin
      step();
      if (hold_timeout) pulses++;
    end
    check("wd_lone_pulses", pulses, 0);
    check("wd_lone_gnt", m_gnt, 2'b01);

    // reset in the middle of master 1's read
    reset_dut();
    m_req = 2'b10;
    wait_gnt(gap);
    check("rs_gnt1", m_gnt, 2'b10);
    m_read = 2'b10;
    #1;
    check("rs_read", int_read, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rs_gnt_drop", m_gnt, 2'b00);
    check("rs_read_drop", int_read, 1'b0);
    check("rs_busy_drop", busy, 1'b0);
    m_read = 2'b00;
    step();
    rst_n = 1'b1;
    m_req = 2'b11;
    wait_gnt(gap);
    check("rs_regrant", m_gnt, 2'b01);

    // read path: register file answers one cycle after int_read
    m_req = 2'b01;
    m_read = 2'b01;
    #1;
    check("rd_strobe", int_read, 1'b1);
    step();
    m_read = 2'b00;
    int_rd_data = 8'h3C;
    #1;
    check("rd_data", m_rd_data, 8'h3C);
    check("rd_gnt_held", m_gnt, 2'b01);
    repeat (4) step();
    check("rd_gnt_still", m_gnt, 2'b01);
    m_req = 2'b00;
    step();
    check("rd_gnt_rel", m_gnt, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
